// File: rtl/cache_mem_pkg.sv
// Shared types and width constants for the cache-to-main-memory request path.
// Used by main_memory_ctrl and main_mem_array.
`timescale 1ns/1ps
package cache_mem_pkg;

   localparam int BLK_W       = 128;
   localparam int OFFSET_BITS = 4;
   localparam int MEM_ADDR_W  = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic                  rw;
      logic [BLK_W-1:0]      data;
   } mem_req_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/main_mem_array.sv
// Single-port synchronous backing store with a registered read port.
// The read register only updates on a read, so it holds the last block read.
`timescale 1ns/1ps
module main_mem_array
   import cache_mem_pkg::*;
#(
   parameter int DATA_W    = BLK_W,
   parameter int LINE_BITS = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 we,
   input  logic [LINE_BITS-1:0] addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic [DATA_W-1:0]    rdata
);

   logic [DATA_W-1:0] mem [0:(1<<LINE_BITS)-1];

   // NOTE: the storage array has no reset branch; resetting every line would
   // turn the RAM into thousands of flops and prevent RAM inference.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency main-memory responder for the cache controller's mem_req_* handshake.
// Optional statistics counters are built only when MAIN_MEM_STATS_EN is defined.
`timescale 1ns/1ps
module main_memory_ctrl
   import cache_mem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = BLK_W,
   parameter int LINE_BITS = 12,
   parameter int LATENCY   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic [DATA_W-1:0] mem_req_dataout,
   input  logic              mem_req_rw,
   input  logic              mem_req_valid,
   output logic [DATA_W-1:0] mem_req_datain,
   output logic              mem_req_ready,
   output logic              req_err,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
);

   localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

   mem_state_t           state_q, state_d;
   mem_req_t             req_q, req_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic                 err_q, err_d;
   logic                 done;
   logic                 arr_en;
   logic [LINE_BITS-1:0] line_idx;
   logic                 unused_addr_bits;

   assign done     = (state_q == BUSY) && (cnt_q == 8'd0);
   // Gating with rst_n keeps a write that completes under reset out of the array.
   assign arr_en   = done && rst_n;
   assign line_idx = req_q.addr[LINE_BITS+OFFSET_BITS-1:OFFSET_BITS];
   assign unused_addr_bits = ^{req_q.addr[MEM_ADDR_W-1:LINE_BITS+OFFSET_BITS],
                               req_q.addr[OFFSET_BITS-1:0]};

   // NOTE: every next-state signal gets its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (mem_req_valid) begin
               req_d.addr = MEM_ADDR_W'(mem_req_addr);
               req_d.rw   = mem_req_rw;
               req_d.data = BLK_W'(mem_req_dataout);
               cnt_d      = LAT_INIT;
               ready_d    = 1'b0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // A request arriving while busy is dropped and only flagged.
            if (mem_req_valid) begin
               err_d = 1'b1;
            end
            if (cnt_q == 8'd0) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   main_mem_array #(
      .DATA_W    (DATA_W),
      .LINE_BITS (LINE_BITS)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arr_en),
      .we    (req_q.rw),
      .addr  (line_idx),
      .wdata (DATA_W'(req_q.data)),
      .rdata (mem_req_datain)
   );

   assign mem_req_ready = ready_q;
   assign req_err       = err_q;

`ifdef MAIN_MEM_STATS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (done) begin
         if (req_q.rw) begin
            wr_cnt_q <= sat_inc32(wr_cnt_q);
         end else begin
            rd_cnt_q <= sat_inc32(rd_cnt_q);
         end
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`else
   assign rd_count = '0;
   assign wr_count = '0;
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed cases plus randomized
// requests scored against a line-indexed reference store.
`timescale 1ns/1ps
module tb_main_memory_ctrl;
   import cache_mem_pkg::*;

   localparam int LAT = 4;
   localparam int LB  = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  mem_req_addr = '0;
   logic [127:0] mem_req_dataout = '0;
   logic         mem_req_rw = 1'b0;
   logic         mem_req_valid = 1'b0;
   logic [127:0] mem_req_datain;
   logic         mem_req_ready;
   logic         req_err;
   logic [31:0]  rd_count;
   logic [31:0]  wr_count;

   always #5 clk = ~clk;

   main_memory_ctrl #(
      .ADDR_W    (32),
      .DATA_W    (128),
      .LINE_BITS (LB),
      .LATENCY   (LAT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_req_addr    (mem_req_addr),
      .mem_req_dataout (mem_req_dataout),
      .mem_req_rw      (mem_req_rw),
      .mem_req_valid   (mem_req_valid),
      .mem_req_datain  (mem_req_datain),
      .mem_req_ready   (mem_req_ready),
      .req_err         (req_err),
      .rd_count        (rd_count),
      .wr_count        (wr_count)
   );

   int unsigned  vectors = 0;
   int unsigned  miscompares = 0;

   logic [127:0] model_mem [int];
   logic [127:0] exp_datain = '0;
   logic         exp_err = 1'b0;
   logic [31:0]  exp_rd = '0;
   logic [31:0]  exp_wr = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 4) % (32'd1 << LB));
   endfunction

   function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef MAIN_MEM_STATS_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic check_status(input string tag);
      check({tag, ".datain"}, mem_req_datain, exp_datain);
      check({tag, ".err"}, 128'(req_err), 128'(exp_err));
      check({tag, ".rd"}, 128'(rd_count), 128'(cnt_exp(exp_rd)));
      check({tag, ".wr"}, 128'(wr_count), 128'(cnt_exp(exp_wr)));
   endtask

   // Called at a negedge with ready high; returns at the negedge where ready is high again.
   // intrude > 0 fires a stray write to junk_addr after that many busy cycles.
   task automatic do_req(input string tag, input logic rw, input logic [31:0] addr,
                         input logic [127:0] data, input int intrude, input logic [31:0] junk_addr);
      int busy;
      mem_req_rw      = rw;
      mem_req_addr    = addr;
      mem_req_dataout = data;
      mem_req_valid   = 1'b1;
      @(posedge clk);
      #1 mem_req_valid = 1'b0;
      busy = 0;
      forever begin
         @(negedge clk);
         if (mem_req_ready) break;
         busy++;
         if (busy == intrude) begin
            mem_req_rw      = 1'b1;
            mem_req_addr    = junk_addr;
            mem_req_dataout = ~data;
            mem_req_valid   = 1'b1;
            exp_err         = 1'b1;
            @(posedge clk);
            #1 mem_req_valid = 1'b0;
         end
         if (busy > 300) begin
            check({tag, ".timeout"}, 128'(busy), 128'(LAT));
            break;
         end
      end
      if (rw) begin
         model_mem[line_of(addr)] = data;
         if (exp_wr != 32'hFFFF_FFFF) exp_wr++;
      end else begin
         exp_datain = model_mem.exists(line_of(addr)) ? model_mem[line_of(addr)] : 'x;
         if (exp_rd != 32'hFFFF_FFFF) exp_rd++;
      end
      check({tag, ".busy"}, 128'(busy), 128'(LAT));
      check_status(tag);
   endtask

   initial begin
      logic [31:0]  a_old, a_new, a;
      logic [127:0] blk_old, blk_new, d;
      int           idx, w;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst.ready", 128'(mem_req_ready), 128'(1));
      check_status("rst");

      // Write then read the same block.
      d = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      do_req("wr4a30", 1'b1, 32'h0000_4A30, d, 0, '0);
      do_req("rd4a30", 1'b0, 32'h0000_4A30, '0, 0, '0);

      // Upper address bits alias onto the same line.
      do_req("alias_wr", 1'b1, 32'h0001_0010, 128'hA5, 0, '0);
      do_req("alias_rd", 1'b0, 32'h0000_0010, '0, 0, '0);

      // Stray request mid-BUSY: dropped, flagged, in-flight request unaffected.
      do_req("pre200", 1'b1, 32'h0000_0200, 128'h2222_0000_1111, 0, '0);
      do_req("intrude", 1'b1, 32'h0000_0300, 128'h3333_CAFE, 2, 32'h0000_0200);
      do_req("chk200", 1'b0, 32'h0000_0200, '0, 0, '0);
      do_req("chk300", 1'b0, 32'h0000_0300, '0, 0, '0);

      // Reset during the second busy cycle of a write aborts it.
      do_req("pre100", 1'b1, 32'h0000_0100, 128'h1001_1001, 0, '0);
      mem_req_rw      = 1'b1;
      mem_req_addr    = 32'h0000_0100;
      mem_req_dataout = 128'hDEAD_BEEF_DEAD_BEEF;
      mem_req_valid   = 1'b1;
      @(posedge clk);
      #1 mem_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      exp_datain = '0;
      exp_err    = 1'b0;
      exp_rd     = '0;
      exp_wr     = '0;
      check("abort.ready", 128'(mem_req_ready), 128'(1));
      check_status("abort");
      rst_n = 1'b1;
      @(negedge clk);
      do_req("rd100", 1'b0, 32'h0000_0100, '0, 0, '0);

      // Cache dirty read miss: write-back of the victim, then allocate read.
      a_old   = 32'h0000_5A40;
      a_new   = 32'h0000_9A44;
      blk_new = 128'h4444_4444_BBBB_BBBB_2222_2222_1111_1111;
      blk_old = 128'h0D0D_0D0D_0C0C_0C0C_0B0B_0B0B_0A0A_0A0A;
      do_req("init_new", 1'b1, {a_new[31:4], 4'h0}, blk_new, 0, '0);
      do_req("wb_old", 1'b1, {a_old[31:4], 4'h0}, blk_old, 0, '0);
      do_req("alloc", 1'b0, a_new, '0, 0, '0);
      w = int'(a_new[3:2]);
      check("alloc.word", 128'(mem_req_datain[w*32 +: 32]), 128'(blk_new[w*32 +: 32]));

      // Randomized traffic over a small pool of lines with random alias bits.
      for (int i = 0; i < 60; i++) begin
         idx = int'($urandom_range(0, 15));
         a   = ($urandom & 32'hFFFF_0000) | (32'(idx) << 4) | ($urandom & 32'hF);
         if (model_mem.exists(line_of(a)) && ($urandom_range(0, 1) == 1)) begin
            do_req("rnd_rd", 1'b0, a, '0, 0, '0);
         end else begin
            d = {$urandom, $urandom, $urandom, $urandom};
            do_req("rnd_wr", 1'b1, a, d, 0, '0);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
